// File: rtl/dtw_accel_ctrl_if.sv
// Signal bundle between the DTW sequencer, its host control port, the sink FIFO and the DTW core.
// core_sample handshake: a beat transfers on any cycle with core_valid && core_ready; while
// core_valid is high and core_ready low, core_sample, core_last and core_valid are held unchanged.
interface dtw_accel_ctrl_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int QLEN_WIDTH   = 16,
  parameter int RESULT_WIDTH = 32
);
  logic                    ctrl_start;
  logic [QLEN_WIDTH-1:0]   ctrl_qlen;
  logic                    ctrl_abort;
  logic                    ctrl_busy;
  logic                    ctrl_done;
  logic [RESULT_WIDTH-1:0] ctrl_result;
  logic [1:0]              ctrl_err;
  logic                    dtw_fifo_rden;
  logic [DATA_WIDTH-1:0]   dtw_fifo_dout;
  logic                    dtw_fifo_empty;
  logic                    core_start;
  logic [DATA_WIDTH-1:0]   core_sample;
  logic                    core_valid;
  logic                    core_ready;
  logic                    core_last;
  logic                    core_done;
  logic [RESULT_WIDTH-1:0] core_score;

  modport slave (
    input  ctrl_start, ctrl_qlen, ctrl_abort, dtw_fifo_dout, dtw_fifo_empty,
           core_ready, core_done, core_score,
    output ctrl_busy, ctrl_done, ctrl_result, ctrl_err, dtw_fifo_rden,
           core_start, core_sample, core_valid, core_last
  );

  modport master (
    output ctrl_start, ctrl_qlen, ctrl_abort, dtw_fifo_dout, dtw_fifo_empty,
           core_ready, core_done, core_score,
    input  ctrl_busy, ctrl_done, ctrl_result, ctrl_err, dtw_fifo_rden,
           core_start, core_sample, core_valid, core_last
  );
endinterface

// File: rtl/dtw_accel_ctrl.sv
// Sequencer that starts a DTW core, streams qlen query samples from a FWFT sink FIFO into it,
// and reports the core's score (or a zero-length / abort / timeout error) to the host.
module dtw_accel_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int QLEN_WIDTH     = 16,
  parameter int RESULT_WIDTH   = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             S_AXIS_ACLK,
  input  logic             S_AXIS_ARESETN,
  dtw_accel_ctrl_if.slave  bus,
  output logic [2:0]       dbg_state
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    STREAM    = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t                state;
  logic [QLEN_WIDTH-1:0] qlen;
  logic [QLEN_WIDTH-1:0] pops;
  logic [TW-1:0]         tmo;
  logic                  pop;
  logic                  hshake;

  // Pop refills the output register whenever it is empty or being drained this cycle.
  // Gated by reset so a reset asserted mid-stream issues no further pop.
  assign pop = S_AXIS_ARESETN && (state == STREAM) && !bus.dtw_fifo_empty &&
               (pops < qlen) && (!bus.core_valid || bus.core_ready);
  assign hshake            = bus.core_valid && bus.core_ready;
  assign bus.dtw_fifo_rden = pop;
  assign bus.ctrl_busy     = (state != IDLE);
  assign dbg_state         = state;

  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      state           <= IDLE;
      qlen            <= '0;
      pops            <= '0;
      tmo             <= '0;
      bus.core_start  <= 1'b0;
      bus.core_valid  <= 1'b0;
      bus.core_last   <= 1'b0;
      bus.core_sample <= {DATA_WIDTH{1'b0}};
      bus.ctrl_done   <= 1'b0;
      bus.ctrl_err    <= 2'd0;
      bus.ctrl_result <= {RESULT_WIDTH{1'b0}};
    end else begin
      bus.core_start <= 1'b0;
      bus.ctrl_done  <= 1'b0;
      // Abort wins over every other event and drops any sample still held for the core.
      if (state != IDLE && bus.ctrl_abort) begin
        state          <= IDLE;
        bus.core_valid <= 1'b0;
        bus.core_last  <= 1'b0;
        bus.ctrl_err   <= 2'd2;
      end else begin
        case (state)
          IDLE: begin
            if (bus.ctrl_start) begin
              if (bus.ctrl_qlen != '0) begin
                qlen           <= bus.ctrl_qlen;
                bus.ctrl_err   <= 2'd0;
                bus.core_start <= 1'b1;
                state          <= START;
              end else begin
                bus.ctrl_err  <= 2'd1;
                bus.ctrl_done <= 1'b1;
              end
            end
          end
          START: begin
            pops  <= '0;
            state <= STREAM;
          end
          STREAM: begin
            if (pop) begin
              bus.core_sample <= bus.dtw_fifo_dout;
              bus.core_valid  <= 1'b1;
              bus.core_last   <= (pops == qlen - 1'b1);
              pops            <= pops + 1'b1;
            end else if (hshake) begin
              bus.core_valid <= 1'b0;
              bus.core_last  <= 1'b0;
              if (bus.core_last) begin
                tmo   <= '0;
                state <= WAIT_DONE;
              end
            end
          end
          WAIT_DONE: begin
            if (bus.core_done) begin
              bus.ctrl_result <= bus.core_score;
              bus.ctrl_done   <= 1'b1;
              state           <= DONE;
            end else if (tmo == TW'(TIMEOUT_CYCLES)) begin
              bus.ctrl_err  <= 2'd3;
              bus.ctrl_done <= 1'b1;
              state         <= DONE;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dtw_accel_ctrl.sv
// Bench for dtw_accel_ctrl: FIFO and core models, sample scoreboard, vector table and corner sequences.
module tb_dtw_accel_ctrl;
  localparam int DW = 8;
  localparam int QW = 16;
  localparam int RW = 32;
  localparam int TO = 8;

  typedef struct {
    int          qlen;
    int          ready_mode;   // 0 always, 1 pattern 1,0,0,1, 2 random
    int          gap_after;    // 0 = no gap
    int          gap_len;
    logic [RW-1:0] score;
    int          done_delay;   // -1 = core never finishes
    bit          stray;        // stray core_done / start-while-busy pokes
    bit          fixed;        // data 0x11,0x22,...
    logic [1:0]  exp_err;
    logic [RW-1:0] exp_result;
    bit          chk_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  dtw_accel_ctrl_if #(.DATA_WIDTH(DW), .QLEN_WIDTH(QW), .RESULT_WIDTH(RW)) bus();

  dtw_accel_ctrl #(.DATA_WIDTH(DW), .QLEN_WIDTH(QW), .RESULT_WIDTH(RW), .TIMEOUT_CYCLES(TO)) dut (
    .S_AXIS_ACLK(clk),
    .S_AXIS_ARESETN(rst_n),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  logic [DW-1:0] fifo_q[$];
  logic [DW:0]   exp_q[$];
  vec_t vecs[6];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_rden, n_cstart, n_cdone, n_hs;
  int first_rden, first_valid, last_hs, cdone_cyc, cstart_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_trackers();
    n_rden = 0; n_cstart = 0; n_cdone = 0; n_hs = 0;
    first_rden = -1; first_valid = -1; last_hs = -1; cdone_cyc = -1; cstart_cyc = -1;
  endtask

  task automatic drive_fifo();
    bus.dtw_fifo_empty = (fifo_q.size() == 0);
    bus.dtw_fifo_dout  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  endtask

  // One clock: sample the current cycle, let the edge happen, then update the FIFO model.
  task automatic tick();
    logic rden_s, hs_s, hold_s, last_s, cs_s, cd_s, emp_s, rst_s, abort_s;
    logic [DW-1:0] samp_s;
    logic [DW:0] e;
    drive_fifo();
    #1;
    rden_s = bus.dtw_fifo_rden; emp_s = bus.dtw_fifo_empty;
    hs_s = bus.core_valid && bus.core_ready;
    hold_s = bus.core_valid && !bus.core_ready;
    samp_s = bus.core_sample; last_s = bus.core_last;
    cs_s = bus.core_start; cd_s = bus.ctrl_done;
    rst_s = rst_n; abort_s = bus.ctrl_abort;
    if (emp_s) chk("rden_when_empty", rden_s, 1'b0);
    if (rden_s) begin n_rden++; if (first_rden < 0) first_rden = cyc; end
    if (cs_s) begin n_cstart++; cstart_cyc = cyc; end
    if (cd_s) begin n_cdone++; cdone_cyc = cyc; end
    if (bus.core_valid && first_valid < 0) first_valid = cyc;
    if (hs_s) begin
      n_hs++;
      if (last_s) last_hs = cyc;
      chk("sb_nonempty", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sample_last_data", {last_s, samp_s}, e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rden_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (hold_s && rst_s && !abort_s) begin
      chk("hold_valid", bus.core_valid, 1'b1);
      chk("hold_sample", bus.core_sample, samp_s);
    end
    drive_fifo();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [DW-1:0] pend_q[$];
    logic [DW-1:0] d;
    int first_batch, gap_wait, t0, rel, done_drv;
    string tag;
    tag = $sformatf("v%0d", idx);
    clear_trackers();
    first_batch = (v.gap_after > 0) ? v.gap_after : v.qlen;
    for (int i = 0; i < v.qlen; i++) begin
      d = v.fixed ? DW'(8'h11 * (i + 1)) : DW'($urandom_range(0, 255));
      if (i < first_batch) fifo_q.push_back(d); else pend_q.push_back(d);
      exp_q.push_back({(i == v.qlen - 1), d});
    end
    bus.core_ready = 1'b1;
    bus.ctrl_qlen = QW'(v.qlen);
    bus.ctrl_start = 1'b1;
    t0 = cyc;
    tick();
    bus.ctrl_start = 1'b0;
    gap_wait = 0; done_drv = -1;
    for (int k = 0; k < 300 && cdone_cyc < 0; k++) begin
      rel = cyc - t0;
      case (v.ready_mode)
        0: bus.core_ready = 1'b1;
        1: bus.core_ready = ((k % 4) == 0) || ((k % 4) == 3);
        default: bus.core_ready = 1'($urandom_range(0, 1));
      endcase
      if (pend_q.size() > 0 && fifo_q.size() == 0) begin
        gap_wait++;
        if (gap_wait > v.gap_len) begin
          chk({tag, "_gap_no_rden"}, n_rden, v.gap_after);
          while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
        end
      end
      bus.core_done = 1'b0;
      bus.core_score = v.score;
      bus.ctrl_start = 1'b0;
      if (v.stray && rel == 3) begin
        bus.core_done = 1'b1;
        bus.core_score = 32'hDEAD_DEAD;
      end
      if (v.stray && rel == 4) begin
        bus.ctrl_start = 1'b1;
        bus.ctrl_qlen = '0;
      end
      if (last_hs >= 0 && v.done_delay >= 0 && cyc == last_hs + 1 + v.done_delay) begin
        bus.core_done = 1'b1;
        bus.core_score = v.score;
        done_drv = cyc;
      end
      tick();
    end
    bus.core_done = 1'b0;
    bus.ctrl_start = 1'b0;
    chk({tag, "_done_seen"}, cdone_cyc >= 0, 1'b1);
    chk({tag, "_err"}, bus.ctrl_err, v.exp_err);
    chk({tag, "_result"}, bus.ctrl_result, v.exp_result);
    chk({tag, "_core_start_cnt"}, n_cstart, 1);
    chk({tag, "_core_start_lat"}, cstart_cyc - t0, 1);
    chk({tag, "_pops"}, n_rden, v.qlen);
    chk({tag, "_handshakes"}, n_hs, v.qlen);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
    if (v.done_delay >= 0) chk({tag, "_done_lat"}, cdone_cyc - done_drv, 1);
    else chk({tag, "_timeout_lat"}, cdone_cyc - last_hs, 10);
    if (v.chk_lat) begin
      chk({tag, "_first_rden"}, first_rden - t0, 2);
      chk({tag, "_first_valid"}, first_valid - t0, 3);
      chk({tag, "_last_hs"}, last_hs - t0, 6);
    end
    tick();
    chk({tag, "_done_pulse"}, n_cdone, 1);
    chk({tag, "_idle"}, bus.ctrl_busy, 1'b0);
  endtask

  initial begin
    int t0;
    vecs[0] = '{4, 0, 0, 0,  32'h0000_1234, 0,  1'b0, 1'b1, 2'd0, 32'h0000_1234, 1'b1};
    vecs[1] = '{3, 1, 0, 0,  32'h0000_BEEF, 2,  1'b1, 1'b0, 2'd0, 32'h0000_BEEF, 1'b0};
    vecs[2] = '{5, 0, 2, 10, 32'hCAFE_0001, 1,  1'b0, 1'b0, 2'd0, 32'hCAFE_0001, 1'b0};
    vecs[3] = '{2, 0, 0, 0,  32'h5555_5555, -1, 1'b0, 1'b0, 2'd3, 32'hCAFE_0001, 1'b0};
    vecs[4] = '{1, 0, 0, 0,  32'h0000_0005, 0,  1'b1, 1'b0, 2'd0, 32'h0000_0005, 1'b0};
    vecs[5] = '{6, 2, 0, 0,  32'h0BAD_F00D, 3,  1'b0, 1'b0, 2'd0, 32'h0BAD_F00D, 1'b0};

    bus.ctrl_start = 1'b0; bus.ctrl_qlen = '0; bus.ctrl_abort = 1'b0;
    bus.core_ready = 1'b0; bus.core_done = 1'b0; bus.core_score = '0;
    drive_fifo();
    clear_trackers();

    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_busy", bus.ctrl_busy, 1'b0);
    chk("rst_done", bus.ctrl_done, 1'b0);
    chk("rst_result", bus.ctrl_result, '0);
    chk("rst_err", bus.ctrl_err, 2'd0);
    chk("rst_core_start", bus.core_start, 1'b0);
    chk("rst_valid", bus.core_valid, 1'b0);
    chk("rst_last", bus.core_last, 1'b0);
    chk("rst_sample", bus.core_sample, '0);
    chk("rst_state", dbg_state, 3'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Zero length request
    clear_trackers();
    bus.ctrl_qlen = '0; bus.ctrl_start = 1'b1;
    tick();
    bus.ctrl_start = 1'b0;
    chk("zl_done", bus.ctrl_done, 1'b1);
    chk("zl_err", bus.ctrl_err, 2'd1);
    chk("zl_busy", bus.ctrl_busy, 1'b0);
    tick();
    chk("zl_done_one_cycle", bus.ctrl_done, 1'b0);
    repeat (3) tick();
    chk("zl_no_core_start", n_cstart, 0);
    chk("zl_no_rden", n_rden, 0);
    chk("zl_done_cnt", n_cdone, 1);

    // Abort during STREAM while a sample is held
    clear_trackers();
    for (int i = 0; i < 4; i++) begin
      fifo_q.push_back(DW'(8'hA0 + i));
      exp_q.push_back({(i == 3), DW'(8'hA0 + i)});
    end
    bus.core_ready = 1'b0;
    bus.ctrl_qlen = QW'(4); bus.ctrl_start = 1'b1;
    tick();
    bus.ctrl_start = 1'b0;
    repeat (3) tick();
    chk("ab_valid_before", bus.core_valid, 1'b1);
    bus.ctrl_abort = 1'b1;
    tick();
    bus.ctrl_abort = 1'b0;
    chk("ab_busy", bus.ctrl_busy, 1'b0);
    chk("ab_valid", bus.core_valid, 1'b0);
    chk("ab_err", bus.ctrl_err, 2'd2);
    chk("ab_state", dbg_state, 3'd0);
    repeat (4) tick();
    chk("ab_no_done", n_cdone, 0);
    chk("ab_pops", n_rden, 1);
    fifo_q.delete();
    exp_q.delete();
    run_vec(vecs[4], 6);

    // Reset during WAIT_DONE
    clear_trackers();
    fifo_q.push_back(8'h5A);
    exp_q.push_back({1'b1, 8'h5A});
    bus.core_ready = 1'b1;
    bus.ctrl_qlen = QW'(1); bus.ctrl_start = 1'b1;
    t0 = cyc;
    tick();
    bus.ctrl_start = 1'b0;
    for (int k = 0; k < 20 && last_hs < 0; k++) tick();
    chk("rs_last_seen", last_hs - t0, 3);
    chk("rs_in_wait", dbg_state, 3'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rs_busy", bus.ctrl_busy, 1'b0);
    chk("rs_valid", bus.core_valid, 1'b0);
    chk("rs_done", bus.ctrl_done, 1'b0);
    chk("rs_result", bus.ctrl_result, '0);
    n_cdone = 0; n_rden = 0;
    bus.core_done = 1'b1; bus.core_score = 32'h7777_7777;
    tick();
    bus.core_done = 1'b0;
    repeat (4) tick();
    chk("rs_no_done", n_cdone, 0);
    chk("rs_no_rden", n_rden, 0);
    chk("rs_result_kept", bus.ctrl_result, '0);
    chk("rs_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
